// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns a MEM-stage load/store into an ack-handshaked
// memory request, freezes the pipeline until completion, and counts stall cycles.
module dmem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [31:0]       stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic              acc;
  logic              stall;

  always_comb begin
    acc       = start_i & (MemRead_i | MemWrite_i);
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    // Outputs follow the reset state, so no stall is reported while rst_i is high.
    stall     = !rst_i && (((state_q == IDLE) && acc) || (state_q == REQ));
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (acc) begin
          addr_d  = addr_i;
          wdata_d = data_i;
          we_d    = MemWrite_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = mem_rdata_i;
          end
        end
      end
      // MEM-stage inputs here still belong to the completed instruction.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_o     = stall;
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign data_o      = rdata_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the MEM stage of the 5-stage pipelined CPU and a variable-latency, ack-handshaked data memory. It replaces the single-cycle data-memory connection: it captures a load/store from the EX/MEM pipeline register, runs the request/acknowledge handshake, and holds `stall_o` high so the pipeline freezes until the access completes. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk_i`  input  1  clock; all state changes on the rising edge.
- `rst_i`  input  1  reset; synchronous, active-high.
- `start_i`  input  1  CPU run enable; while low, no new access is accepted.
- `MemRead_i`  input  1  MEM-stage load request (EX/MEM register).
- `MemWrite_i`  input  1  MEM-stage store request.
- `addr_i`  input  ADDR_W  MEM-stage address (ALU result).
- `data_i`  input  DATA_W  MEM-stage store data.
- `data_o`  output  DATA_W  last completed load data, to MEM/WB.
- `stall_o`  output  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB.
- `mem_req_o`  output  1  memory request valid.
- `mem_we_o`  output  1  1 = write, 0 = read.
- `mem_addr_o`  output  ADDR_W  latched request address.
- `mem_wdata_o`  output  DATA_W  latched write data.
- `mem_ack_i`  input  1  memory completion, one cycle per request.
- `mem_rdata_i`  input  DATA_W  read data, valid with `mem_ack_i`.
- `stall_cnt_o`  output  32  stall cycles since reset, saturating.

## Operation
- The FSM has three states: IDLE, REQ and DONE. Registered state, 2-bit encoding.
- IDLE:
  - A new access is `acc = start_i & (MemRead_i | MemWrite_i)`.
  - On `acc`, latch `addr_i`→`mem_addr_o`, `data_i`→`mem_wdata_o`, `MemWrite_i`→`mem_we_o`, then go to REQ.
  - If `MemRead_i` and `MemWrite_i` are both high, the access is a write.
- REQ:
  - `mem_req_o`=1. Address, data and we are held stable.
  - On `mem_ack_i`: go to DONE; if `!mem_we_o`, latch `mem_rdata_i`→`data_o`.
  - Without an ack, stay in REQ indefinitely. There is no timeout.
- DONE:
  - `stall_o`=0 so the pipeline advances exactly once. Go to IDLE unconditionally.
  - Requests on the MEM-stage inputs in this cycle belong to the completed instruction and are ignored.
- `stall_o` is combinational: `(IDLE & acc) | REQ`. It is 0 in DONE and in IDLE without `acc`.
- `mem_ack_i` is ignored outside REQ.
- `data_o` holds the last read value across writes and idle cycles.
- `stall_cnt_o`: +1 every cycle with `stall_o`=1. It saturates at 0xFFFFFFFF and does not wrap.
- `start_i` falling while in REQ or DONE does not abort; the access completes normally.
- Reset (any state, including mid-REQ):
  - next state is IDLE; `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `data_o`=0, `stall_cnt_o`=0.
  - An in-flight access is abandoned, and a late ack after reset is ignored.

## Timing
- Access seen in IDLE at cycle t: `stall_o`=1 at t (combinational).
- REQ from t+1: `mem_req_o`=1 from t+1.
- Ack sampled at cycle t+a (a ≥ 1; an ack in the first REQ cycle gives a=1).
- DONE at t+a+1: `stall_o`=0, `data_o` valid. IDLE at t+a+2.
- Stall length is a+1 cycles; the minimum total access time is 3 cycles.
- Back-to-back accesses: the next MEM-stage access is first seen in IDLE at t+a+2. There is no gap cycle beyond DONE.
- Reset values: `stall_o`=0 (IDLE, and `acc` is irrelevant during reset because outputs follow the reset state), all outputs 0.

## Test plan
- Reset, then load with `addr_i`=0x40 and ack after 3 REQ cycles, `mem_rdata_i`=0xDEADBEEF:
  - `mem_req_o` high for 3 cycles, `mem_addr_o`=0x40, `mem_we_o`=0;
  - `stall_o` high 4 cycles; `data_o`=0xDEADBEEF in DONE; `stall_cnt_o`=4.
- Store with `addr_i`=0x10, `data_i`=0x12345678, ack in the first REQ cycle:
  - `mem_we_o`=1, `mem_wdata_o`=0x12345678, `stall_o` high 2 cycles;
  - `data_o` keeps its previous value.
- `MemRead_i` held high continuously for two consecutive loads (immediate acks):
  - exactly two requests are issued, separated by DONE; no duplicate request in DONE.
- `start_i`=0 with `MemRead_i`=1: no request issued, `stall_o`=0, `stall_cnt_o` unchanged.
- Assert `rst_i` for 1 cycle mid-REQ, then drive a late `mem_ack_i`:
  - state is IDLE, `mem_req_o`=0, `stall_cnt_o`=0, `data_o`=0; the late ack causes no change.
- `stall_cnt_o` preloaded near saturation via a long-stall run: it holds at 0xFFFFFFFF and does not wrap.
